clint_timer: RTL and testbench
==============================

# clint_timer

Memory-mapped machine timer and software-interrupt source, the producer end of the core-local interrupt controller's `timer_int_i`. Holds `msip`, `mtime` and `mtimecmp` behind a single-outstanding request/response slave port on the SoC bus. Drives the level timer and software interrupt lines into the core.

## Interface
Parameters:
- `BASE_ADDR`, 64'h0200_0000: base of the 64 KiB timer window.
- `TICK_DIV`, 1: `clk` cycles per `mtime` increment (≥1).

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_wen` in 1: 1 = write, 0 = read.
- `req_addr` in 64: byte address. `[2:0]` ignored.
- `req_wdata` in 64: write data.
- `req_wstrb` in 8: byte enables, writes only.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: response consumed when `resp_valid & resp_ready`.
- `resp_rdata` out 64: read data. 0 for writes and errors.
- `resp_err` out 1: unmapped address.
- `timer_int_o` out 1: machine timer interrupt, level.
- `soft_int_o` out 1: machine software interrupt, equals `msip`.

## Operation
- Register map, offsets from `BASE_ADDR`:
  - 0x0000 `msip`: only bit 0 is stored. Reads return `{63'b0, msip}`.
  - 0x4000 `mtimecmp`: 64 bits.
  - 0xBFF8 `mtime`: 64 bits.
- Any other offset, or any address outside the window, sets `resp_err=1`, returns rdata 0 and changes no state.
- Writes merge per byte: `reg[8i+7:8i] <= wstrb[i] ? wdata[8i+7:8i] : reg[8i+7:8i]`. For `msip`, only `wstrb[0]` and bit 0 matter.
- Prescaler: a counter of width `$clog2(TICK_DIV)+1` counts 0..TICK_DIV-1.
  - At TICK_DIV-1 it returns to 0 and `mtime` increments by 1.
  - `mtime` wraps modulo 2^64 (all-ones → 0).
- Simultaneous tick and `mtime` write: the written bytes win. Unwritten bytes take the incremented value. The prescaler is never affected by bus writes.
- Interrupt: `timer_int_o <= (mtime >= mtimecmp)`, an unsigned 64-bit compare on the current register values, re-evaluated every cycle.
- Handshake FSM, states IDLE and RESP:
  - IDLE: `req_ready=1`. On accept, perform the read/write and go to RESP.
  - RESP: `req_ready=0`, `resp_valid=1`. `resp_rdata` and `resp_err` are held stable. On `resp_ready`, go to IDLE. No back-to-back accept in the same cycle.
- Read data is the register value in the accept cycle, before that cycle's tick takes effect.

## Timing
- Reset values: `mtime=0`, `mtimecmp=64'hFFFF_FFFF_FFFF_FFFF`, `msip=0`, prescaler=0, FSM=IDLE.
- Reset output values: `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `timer_int_o=0`, `soft_int_o=0`.
- Request-to-response latency is 1 cycle. A response may be held indefinitely by `resp_ready=0`, while `mtime` keeps counting.
- Interrupt latency: `timer_int_o` rises the cycle after the register cycle in which `mtime >= mtimecmp` first holds.
  - A `mtimecmp` write accepted in cycle N changes `timer_int_o` in cycle N+2.
  - `soft_int_o` follows an `msip` write from cycle N+1.
- On `mtime` wrap to 0, `timer_int_o` drops one cycle later unless `mtimecmp==0`.
- `rst_n` low during RESP drops `resp_valid` on the next edge. The pending response is discarded.

## Structure
- Shared package/defines: `CLINT_MSIP_OFS`, `CLINT_MTIMECMP_OFS`, `CLINT_MTIME_OFS`, and the 64 KiB window mask. Bus request/response widths are shared with other SoC slaves.
- One natural sub-module: `clint_prescaler`, which takes `clk`, `rst_n` and outputs a `tick` pulse. Everything else is flat.

## Test plan
- Reset, then read 0xBFF8 immediately: resp 1 cycle later with small `mtime`, `resp_err=0`. Read 0x4000 returns all-ones. `timer_int_o=0`.
- TICK_DIV=4, idle 40 cycles: `mtime` advances by exactly 10. Back-to-back reads differ by ≤1.
- Write `mtimecmp`=`mtime`+5: `timer_int_o` rises within 5×TICK_DIV+2 cycles. Then write `mtimecmp`=all-ones: `timer_int_o` low at N+2.
- Write `mtime`=64'hFFFF_FFFF_FFFF_FFFE, wstrb=8'hFF, with `mtimecmp`=2: `timer_int_o`=1 until wrap, then 0 until `mtime`≥2, then 1.
- Write 0x4000 data 64'h1122_3344_5566_7788 with wstrb=8'h0F over all-ones: readback 64'hFFFF_FFFF_5566_7788. Write `msip` bit0=1: `soft_int_o`=1 next cycle.
- Read 0x1000 with `resp_ready` low for 5 cycles: `resp_valid` held, `resp_err=1`, rdata 0, `req_ready=0` throughout. Then assert `rst_n` low mid-response: `resp_valid=0` next cycle.

Source files
------------

// File: rtl/clint_timer_pkg.sv
// Shared bus widths, CLINT register offsets and helpers for the machine timer block.
package clint_timer_pkg;
    localparam int BUS_AW = 64;
    localparam int BUS_DW = 64;
    localparam int BUS_SW = BUS_DW / 8;

    localparam logic [15:0] CLINT_MSIP_OFS     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFS = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFS    = 16'hBFF8;
    localparam logic [63:0] CLINT_WIN_MASK     = 64'h0000_0000_0000_FFFF;

    typedef enum logic {ST_IDLE, ST_RESP} bus_state_e;
    typedef enum logic [1:0] {SEL_NONE, SEL_MSIP, SEL_MTIMECMP, SEL_MTIME} reg_sel_e;

    function automatic logic [BUS_DW-1:0] merge_bytes(input logic [BUS_DW-1:0] old_val,
                                                      input logic [BUS_DW-1:0] new_val,
                                                      input logic [BUS_SW-1:0] strb);
        logic [BUS_DW-1:0] r;
        r = old_val;
        for (int i = 0; i < BUS_SW; i++)
            if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/clint_timer_if.sv
// Single-outstanding request/response bus shared by SoC slaves.
interface clint_timer_if;
    import clint_timer_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [BUS_AW-1:0] req_addr;
    logic [BUS_DW-1:0] req_wdata;
    logic [BUS_SW-1:0] req_wstrb;
    logic              resp_valid;
    logic              resp_ready;
    logic [BUS_DW-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/clint_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, untouched by bus traffic.
module clint_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + CW'(1);
    end
endmodule

// File: rtl/clint_timer.sv
// Machine timer / software interrupt source: msip, mtimecmp and mtime behind a
// single-outstanding bus slave, driving level interrupt lines into the core.
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    clint_timer_if.slave bus,
    output logic         timer_int_o,
    output logic         soft_int_o
);
    bus_state_e        state, state_nxt;
    reg_sel_e          sel;
    logic              tick, accept, wr, req_ready, resp_valid;
    logic              msip, err_q;
    logic [15:0]       ofs;
    logic [BUS_DW-1:0] mtime, mtimecmp, mtime_base, mtime_nxt, rd_val, rdata_q;

    clint_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign ofs    = {bus.req_addr[15:3], 3'b000};
    assign accept = (state == ST_IDLE) & bus.req_valid;
    assign wr     = accept & bus.req_wen;

    always_comb begin
        sel = SEL_NONE;
        if ((bus.req_addr & ~CLINT_WIN_MASK) == BASE_ADDR) begin
            case (ofs)
                CLINT_MSIP_OFS:     sel = SEL_MSIP;
                CLINT_MTIMECMP_OFS: sel = SEL_MTIMECMP;
                CLINT_MTIME_OFS:    sel = SEL_MTIME;
                default:            sel = SEL_NONE;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_MSIP:     rd_val = {63'b0, msip};
            SEL_MTIMECMP: rd_val = mtimecmp;
            SEL_MTIME:    rd_val = mtime;
            default:      rd_val = '0;
        endcase
    end

    // Written bytes override the tick; unwritten bytes still see the increment.
    always_comb begin
        mtime_base = tick ? mtime + 64'd1 : mtime;
        mtime_nxt  = mtime_base;
        if (wr && sel == SEL_MTIME)
            mtime_nxt = merge_bytes(mtime_base, bus.req_wdata, bus.req_wstrb);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime       <= '0;
            mtimecmp    <= '1;
            msip        <= 1'b0;
            timer_int_o <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            mtime       <= mtime_nxt;
            timer_int_o <= (mtime >= mtimecmp);
            if (wr && sel == SEL_MTIMECMP)
                mtimecmp <= merge_bytes(mtimecmp, bus.req_wdata, bus.req_wstrb);
            if (wr && sel == SEL_MSIP && bus.req_wstrb[0])
                msip <= bus.req_wdata[0];
            if (accept) begin
                rdata_q <= bus.req_wen ? '0 : rd_val;
                err_q   <= (sel == SEL_NONE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (bus.resp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign soft_int_o     = msip;
endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer with TICK_DIV=4: bus access, counting, compare and wrap.
module tb_clint_timer;
    localparam logic [63:0] BASE = 64'h0200_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk, rst_n, timer_int, soft_int;
    int   n_assert = 0;
    int   n_fail   = 0;

    clint_timer_if bus();

    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .timer_int_o(timer_int),
        .soft_int_o (soft_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts just after a rising edge; the request is accepted at the next edge,
    // response seen one cycle later and consumed (resp_ready assumed high).
    task automatic xfer(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] strb, output logic [63:0] rdata, output logic err);
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = strb;
        @(negedge clk);
        check("req_ready_at_accept", {63'b0, bus.req_ready}, 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("resp_valid_latency", {63'b0, bus.resp_valid}, 64'd1);
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [63:0] rd, t0, t1, t2, t3;
        logic        er;
        logic        tr [0:23];
        bit          seen;
        int          first0, zeros;

        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.req_wstrb = '0; bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",  {63'b0, bus.req_ready}, 64'd1);
        check("rst_resp_valid", {63'b0, bus.resp_valid}, 64'd0);
        check("rst_resp_rdata", bus.resp_rdata, 64'd0);
        check("rst_resp_err",   {63'b0, bus.resp_err}, 64'd0);
        check("rst_timer_int",  {63'b0, timer_int}, 64'd0);
        check("rst_soft_int",   {63'b0, soft_int}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        xfer(1'b0, BASE + 64'hBFF8, '0, '0, rd, er);
        check("mtime_after_reset", rd, 64'd0);
        check("mtime_after_reset_err", {63'b0, er}, 64'd0);
        xfer(1'b0, BASE + 64'h4000, '0, '0, rd, er);
        check("mtimecmp_reset", rd, ONES);
        check("mtimecmp_reset_err", {63'b0, er}, 64'd0);
        check("timer_int_idle", {63'b0, timer_int}, 64'd0);

        // accept cycles of the two reads are exactly 40 clocks apart
        xfer(1'b0, BASE + 64'hBFF8, '0, '0, t0, er);
        repeat (38) @(posedge clk);
        #1;
        xfer(1'b0, BASE + 64'hBFF8, '0, '0, t1, er);
        check("mtime_40_cycles", t1 - t0, 64'd10);
        xfer(1'b0, BASE + 64'hBFF8, '0, '0, t2, er);
        xfer(1'b0, BASE + 64'hBFF8, '0, '0, t3, er);
        check("back_to_back_delta", {63'b0, (t3 - t2) <= 64'd1}, 64'd1);

        xfer(1'b1, BASE + 64'h4000, t3 + 64'd5, 8'hFF, rd, er);
        check("write_rdata_zero", rd, 64'd0);
        check("write_err", {63'b0, er}, 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (timer_int) begin seen = 1'b1; break; end
        end
        check("timer_int_rises", {63'b0, seen}, 64'd1);
        @(posedge clk); #1;
        xfer(1'b1, BASE + 64'h4000, ONES, 8'hFF, rd, er);
        @(negedge clk);
        check("timer_int_drop_n2", {63'b0, timer_int}, 64'd0);
        @(posedge clk); #1;

        xfer(1'b1, BASE + 64'h4000, 64'd2, 8'hFF, rd, er);
        xfer(1'b1, BASE + 64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, er);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            tr[k] = timer_int;
        end
        first0 = -1;
        for (int i = 0; i < 24; i++) if (first0 < 0 && !tr[i]) first0 = i;
        zeros = 0;
        if (first0 >= 0)
            for (int i = first0; i < 24 && !tr[i]; i++) zeros++;
        check("wrap_high_before", {63'b0, tr[0]}, 64'd1);
        check("wrap_drop_window", {63'b0, first0 >= 5 && first0 <= 8}, 64'd1);
        check("wrap_low_cycles", 64'(zeros), 64'd8);
        @(posedge clk); #1;
        xfer(1'b0, BASE + 64'hBFF8, '0, '0, rd, er);
        check("mtime_wrapped_small", {63'b0, rd < 64'd16}, 64'd1);

        xfer(1'b1, BASE + 64'h4000, ONES, 8'hFF, rd, er);
        xfer(1'b1, BASE + 64'h4000, 64'h1122_3344_5566_7788, 8'h0F, rd, er);
        xfer(1'b0, BASE + 64'h4000, '0, '0, rd, er);
        check("mtimecmp_partial", rd, 64'hFFFF_FFFF_5566_7788);

        check("soft_int_before", {63'b0, soft_int}, 64'd0);
        bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_addr = BASE;
        bus.req_wdata = 64'd1; bus.req_wstrb = 8'h01;
        @(negedge clk);
        check("soft_int_accept_cycle", {63'b0, soft_int}, 64'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("soft_int_next_cycle", {63'b0, soft_int}, 64'd1);
        @(posedge clk); #1;
        xfer(1'b1, BASE, 64'd0, 8'hFE, rd, er);
        xfer(1'b0, BASE, '0, '0, rd, er);
        check("msip_strobe_ignored", rd, 64'd1);

        xfer(1'b0, BASE + 64'h1_4000, '0, '0, rd, er);
        check("out_of_window_err", {63'b0, er}, 64'd1);
        check("out_of_window_rdata", rd, 64'd0);
        xfer(1'b1, BASE + 64'h4008, 64'd0, 8'hFF, rd, er);
        check("unmapped_write_err", {63'b0, er}, 64'd1);
        xfer(1'b0, BASE + 64'h4000, '0, '0, rd, er);
        check("unmapped_write_no_effect", rd, 64'hFFFF_FFFF_5566_7788);

        bus.resp_ready = 1'b0;
        bus.req_valid = 1'b1; bus.req_wen = 1'b0; bus.req_addr = BASE + 64'h1000;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_resp_valid", {63'b0, bus.resp_valid}, 64'd1);
            check("hold_resp_err",   {63'b0, bus.resp_err}, 64'd1);
            check("hold_resp_rdata", bus.resp_rdata, 64'd0);
            check("hold_req_ready",  {63'b0, bus.req_ready}, 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_resp_valid", {63'b0, bus.resp_valid}, 64'd0);
        check("rst_mid_req_ready",  {63'b0, bus.req_ready}, 64'd1);
        check("rst_mid_soft_int",   {63'b0, soft_int}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.resp_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
